// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle, valid/ready on both sides.
// Optional macro BIN2BCD_OVF_SAT_EN: saturate bcd to all nines when the value overflows N/4 digits.
module bin2bcd_seq #(
  parameter int N = 8,
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] bcd,
  output logic         ovf
);

  // The scratch carries one digit more than the output so overflow can be detected.
  localparam int S  = N + 4;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [S-1:0]   scratch_r;
  logic [S-1:0]   adj_s;
  logic [S-1:0]   scratch_nxt_s;
  logic [W-1:0]   bin_r;
  logic [W-1:0]   bin_nxt_s;
  logic [CW-1:0]  cnt_r;
  logic [N-1:0]   bcd_r;
  logic [N-1:0]   bcd_nxt_s;
  logic           ovf_r;
  logic           ovf_nxt_s;
  logic           accept_s;
  logic           last_step_s;

  function automatic logic [S-1:0] dabble_adjust(input logic [S-1:0] s);
    logic [S-1:0] r;
    r = s;
    for (int i = 0; i < S / 4; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  assign in_ready    = (state_r == IDLE) && !rst;
  assign out_valid   = (state_r == DONE);
  assign bcd         = bcd_r;
  assign ovf         = ovf_r;
  assign accept_s    = in_valid && in_ready;
  assign last_step_s = (cnt_r == CNT_ONE);

  // One double-dabble step on the current scratch/operand pair, plus the result it would register.
  always_comb begin
    adj_s                      = dabble_adjust(scratch_r);
    {scratch_nxt_s, bin_nxt_s} = {adj_s, bin_r} << 1;
    ovf_nxt_s                  = |scratch_nxt_s[S-1:N];
`ifdef BIN2BCD_OVF_SAT_EN
    if (ovf_nxt_s) begin
      bcd_nxt_s = {(N/4){4'h9}};
    end else begin
      bcd_nxt_s = scratch_nxt_s[N-1:0];
    end
`else
    bcd_nxt_s = scratch_nxt_s[N-1:0];
`endif
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = SHIFT;
        else          state_nxt_s = IDLE;
      end
      SHIFT: begin
        if (last_step_s) state_nxt_s = DONE;
        else             state_nxt_s = SHIFT;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Datapath: capture on accept, step while shifting, register result on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      scratch_r <= {S{1'b0}};
      bin_r     <= {W{1'b0}};
      cnt_r     <= {CW{1'b0}};
      bcd_r     <= {N{1'b0}};
      ovf_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            bin_r     <= bin;
            scratch_r <= {S{1'b0}};
            cnt_r     <= CNT_LOAD;
          end
        end
        SHIFT: begin
          scratch_r <= scratch_nxt_s;
          bin_r     <= bin_nxt_s;
          cnt_r     <= cnt_r - CNT_ONE;
          if (last_step_s) begin
            bcd_r <= bcd_nxt_s;
            ovf_r <= ovf_nxt_s;
          end
        end
        DONE: begin
          // Result held until the consumer takes it.
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: accepts push expected results, a negedge monitor pops and compares.
module tb_bin2bcd_seq;
  localparam int N = 8;
  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] bin;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] bcd;
  logic         ovf;

  bin2bcd_seq #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] bcd;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  logic [N-1:0] exp_bcd;
  logic         exp_ovf;
  logic         ov_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [N-1:0] enc(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic logic [N-1:0] ref_bcd(input int v);
`ifdef BIN2BCD_OVF_SAT_EN
    if (v > 99) return 8'h99;
    else        return enc(v);
`else
    return enc(v % 100);
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Accept tracker: the accept edge is the next posedge, numbered cyc+1.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) q.push_back('{exp_bcd, exp_ovf, cyc + 1});
  end

  // Monitor: latency on first valid cycle, value/stability every valid cycle, pop on handshake.
  always @(negedge clk) begin
    if (rst) begin
      ov_prev <= 1'b0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          if (!ov_prev) chk("latency", cyc - q[0].acc, W);
          chk("bcd", {24'd0, bcd}, {24'd0, q[0].bcd});
          chk("ovf", {31'd0, ovf}, {31'd0, q[0].ovf});
          chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
          if (out_ready) void'(q.pop_front());
        end
      end
      ov_prev <= out_valid;
    end
  end

  task automatic send(input logic [W-1:0] b, input logic [N-1:0] eb, input logic eo);
    bin      = b;
    exp_bcd  = eb;
    exp_ovf  = eo;
    in_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bin      = W'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; bin = 7'd5; out_ready = 1'b1;
    exp_bcd = 8'h00; exp_ovf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_bcd", {24'd0, bcd}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;

    // Zero, then 53 with the one-cycle valid / in_ready-after checks.
    send(7'd0, 8'h00, 1'b0);
    drain();
    send(7'd53, 8'h53, 1'b0);
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    @(negedge clk);
    chk("valid_one_cycle", {31'd0, out_valid}, 32'd0);
    chk("in_ready_after", {31'd0, in_ready}, 32'd1);

    // Back-to-back 99 and 127 (overflow).
    send(7'd99, 8'h99, 1'b0);
`ifdef BIN2BCD_OVF_SAT_EN
    send(7'd127, 8'h99, 1'b1);
`else
    send(7'd127, 8'h27, 1'b1);
`endif
    drain();

    // Backpressure with input noise.
    out_ready = 1'b0;
    send(7'd42, 8'h42, 1'b0);
    repeat (27) begin
      @(posedge clk);
      #1;
      bin = W'($urandom);
      in_valid = 1'b1;
    end
    @(negedge clk);
    chk("held_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset on the 4th shift edge discards the result.
    send(7'd85, 8'h85, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_bcd", {24'd0, bcd}, 32'd0);
    chk("midrst_ovf", {31'd0, ovf}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    send(7'd12, 8'h12, 1'b0);
    drain();

    // Full sweep against the decimal reference model.
    for (int v = 0; v < 128; v++) begin
      send(W'(v), ref_bcd(v), (v > 99) ? 1'b1 : 1'b0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the BCD output width in bits (N/4 digits, N a multiple of 4).
REQ-002 The block SHALL have parameter W, default 7, giving the binary input width; legal only if 2^W-1 < 10^(N/4+1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: bin holds a value to convert.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts bin this cycle.
REQ-007 The block SHALL have port bin, input, W bits: unsigned binary operand.
REQ-008 The block SHALL have port out_valid, output, 1 bit: bcd and ovf hold a finished result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream consumer (two-digit BCD adder operand stage) takes the result.
REQ-010 The block SHALL have port bcd, output, N bits: packed BCD result, digit 0 in bcd[3:0].
REQ-011 The block SHALL have port ovf, output, 1 bit: input value exceeded 10^(N/4)-1.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 in_ready SHALL equal (state==IDLE && !rst); out_valid SHALL equal (state==DONE).
REQ-014 Input handshake: on the edge where in_valid && in_ready, the block SHALL capture bin, clear the (N+4)-bit digit scratch, load iteration counter with W, and go to SHIFT.
REQ-015 bin SHALL be sampled only at the accept edge; later changes SHALL NOT affect the result.
REQ-016 Each SHIFT edge SHALL perform one double-dabble step: add 3 to every scratch digit >= 5, then shift {scratch, binary} left by one, then decrement the counter.
REQ-017 After the W-th step the block SHALL enter DONE, registering bcd and ovf in the same edge; out_valid SHALL be high exactly W cycles after the accept edge.
REQ-018 ovf SHALL be 1 iff the top scratch digit (extra digit above the N/4 output digits) is non-zero.
REQ-019 In DONE, bcd and ovf SHALL remain stable while out_ready is low (unbounded backpressure).
REQ-020 On the edge where out_valid && out_ready the block SHALL return to IDLE; in_ready SHALL rise the following cycle (no same-cycle bypass; minimum throughput one result per W+2 cycles).
REQ-021 bcd and ovf SHALL hold their last value in IDLE and SHIFT; only out_valid qualifies them.
REQ-022 in_valid asserted outside IDLE SHALL be ignored (no queuing).

Reset
REQ-023 rst high at a rising edge SHALL force IDLE, counter 0, scratch 0, bcd 0, ovf 0, out_valid 0, regardless of state, including mid-SHIFT or DONE with pending result (result discarded).
REQ-024 While rst is high in_ready SHALL be 0; an in_valid during reset SHALL NOT be accepted.

Configuration
REQ-025 Macro BIN2BCD_OVF_SAT_EN SHALL select overflow handling.
REQ-026 With BIN2BCD_OVF_SAT_EN defined, when ovf=1 bcd SHALL saturate to all digits 9 (0x99 for N=8).
REQ-027 Without BIN2BCD_OVF_SAT_EN, when ovf=1 bcd SHALL carry the low N/4 digits (value mod 10^(N/4)); ovf SHALL be produced identically in both builds.

Verification
REQ-028 Reset then bin=0, in_valid=1 -> accepted next edge, out_valid after 7 cycles, bcd=0x00, ovf=0.
REQ-029 bin=53 accepted, out_ready=1 -> bcd=0x53, ovf=0, out_valid high one cycle, in_ready high the cycle after.
REQ-030 bin=99 then bin=127 back-to-back -> 0x99/ovf=0; then ovf=1 with bcd=0x99 (SAT build) or 0x27 (non-SAT build).
REQ-031 bin=42 accepted, out_ready held low 20 cycles, bin toggled meanwhile -> bcd=0x42 stable, out_valid high throughout, in_ready low; released on out_ready=1.
REQ-032 bin=85 accepted, rst pulsed on 4th SHIFT cycle -> IDLE, out_valid=0, bcd=0x00; next bin=12 converts to 0x12.
REQ-033 Exhaustive sweep bin=0..127 in both builds against a reference model -> every bcd/ovf correct, latency exactly 7 cycles each.
